// File: rtl/execute_memory_writeback.sv
// execute_memory_writeback: EX and MEM pipeline stages with word-addressed data memory.
// Define OVERFLOW_TRAP_EN to suppress write-back on signed add/sub overflow and raise a sticky ovf_flag.
module execute_memory_writeback #(
  parameter int DM_DEPTH = 256,
  parameter int DM_AW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [31:0] SD,
  input  logic [4:0]  RD,
  input  logic [2:0]  ALUctr,
  output logic [4:0]  MW_RD,
  output logic [31:0] MW_ALUout,
  output logic        ovf_flag
);
  typedef enum logic [1:0] {OP_ALU, OP_LOAD, OP_STORE, OP_NOP} op_t;
  logic [31:0] w_sum, w_diff, w_res;
  logic [4:0]  w_rd;
  op_t         w_op;
  logic        w_ovf;
  logic [31:0] r_xm_aluout, r_xm_sd;
  logic [4:0]  r_xm_rd;
  op_t         r_xm_op;
  logic [31:0] r_dm [DM_DEPTH];
  logic [DM_AW-1:0] w_addr;
  assign w_sum  = A + B;
  assign w_diff = A - B;
  assign w_addr = r_xm_aluout[DM_AW+1:2];
`ifdef OVERFLOW_TRAP_EN
  assign w_ovf = (ALUctr == 3'd0 && A[31] == B[31] && w_sum[31] != A[31]) ||
                 (ALUctr == 3'd1 && A[31] != B[31] && w_diff[31] != A[31]);
`else
  assign w_ovf = 1'b0;
`endif
  always_comb begin
    w_res = ALUctr == 3'd1 ? w_diff : ALUctr == 3'd2 ? {31'b0, $signed(A) < $signed(B)} : w_sum;
    w_op  = ALUctr <= 3'd2 ? OP_ALU : ALUctr == 3'd3 ? OP_LOAD : ALUctr == 3'd4 ? OP_STORE : OP_NOP;
    w_rd  = (w_op == OP_ALU || w_op == OP_LOAD) && !w_ovf ? RD : 5'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_xm_aluout <= '0;
      r_xm_sd     <= '0;
      r_xm_rd     <= '0;
      r_xm_op     <= OP_ALU;
      MW_RD       <= '0;
      MW_ALUout   <= '0;
    end else begin
      r_xm_aluout <= w_res;
      r_xm_sd     <= SD;
      r_xm_rd     <= w_rd;
      r_xm_op     <= w_op;
      MW_RD       <= (r_xm_op == OP_ALU || r_xm_op == OP_LOAD) ? r_xm_rd : 5'd0;
      MW_ALUout   <= r_xm_op == OP_LOAD ? r_dm[w_addr] : r_xm_op == OP_NOP ? 32'd0 : r_xm_aluout;
    end
  // Memory has no reset; an in-flight store is dropped because reset clears the XM stage.
  always_ff @(posedge clk)
    if (!rst && r_xm_op == OP_STORE) r_dm[w_addr] <= r_xm_sd;
`ifdef OVERFLOW_TRAP_EN
  logic r_xm_ovf;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_xm_ovf <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      r_xm_ovf <= w_ovf;
      ovf_flag <= ovf_flag | r_xm_ovf;
    end
`else
  assign ovf_flag = 1'b0;
`endif
endmodule

// File: tb/tb_execute_memory_writeback.sv
// tb_execute_memory_writeback: directed checks of ALU ops, load/store, address wrap, reset and overflow.
module tb_execute_memory_writeback;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] A = '0, B = '0, SD = '0;
  logic [4:0]  RD = '0;
  logic [2:0]  ALUctr = 3'd7;
  logic [4:0]  MW_RD;
  logic [31:0] MW_ALUout;
  logic        ovf_flag;
  int checks = 0, errors = 0;

  execute_memory_writeback dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .SD(SD), .RD(RD), .ALUctr(ALUctr),
    .MW_RD(MW_RD), .MW_ALUout(MW_ALUout), .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] sd, input logic [4:0] rd);
    ALUctr = c; A = a; B = b; SD = sd; RD = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One instruction followed by a nop, leaving the result on the write-back outputs.
  task automatic exec(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] sd, input logic [4:0] rd);
    drive(c, a, b, sd, rd);
    tick();
    drive(3'd7, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    #12;
    chk("reset_rd", {27'b0, MW_RD}, 32'd0);
    chk("reset_alu", MW_ALUout, 32'd0);
    chk("reset_ovf", {31'b0, ovf_flag}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exec(3'd0, 32'd5, 32'd7, 32'd0, 5'd3);
    chk("add_rd", {27'b0, MW_RD}, 32'd3);
    chk("add_alu", MW_ALUout, 32'd12);
    exec(3'd1, 32'd5, 32'd7, 32'd0, 5'd4);
    chk("sub_rd", {27'b0, MW_RD}, 32'd4);
    chk("sub_alu", MW_ALUout, 32'hFFFFFFFE);
    exec(3'd2, 32'hFFFFFFFF, 32'd1, 32'd0, 5'd2);
    chk("slt_true", MW_ALUout, 32'd1);
    exec(3'd2, 32'd1, 32'hFFFFFFFF, 32'd0, 5'd2);
    chk("slt_false", MW_ALUout, 32'd0);
    chk("slt_rd", {27'b0, MW_RD}, 32'd2);
    exec(3'd6, 32'd9, 32'd9, 32'd0, 5'd7);
    chk("nop_rd", {27'b0, MW_RD}, 32'd0);
    chk("nop_alu", MW_ALUout, 32'd0);
    // back-to-back store then load of the same word
    drive(3'd4, 32'h10, 32'd4, 32'hDEADBEEF, 5'd9);
    tick();
    drive(3'd3, 32'h10, 32'd4, 32'd0, 5'd8);
    tick();
    chk("sw_rd", {27'b0, MW_RD}, 32'd0);
    chk("sw_alu", MW_ALUout, 32'h14);
    drive(3'd7, 0, 0, 0, 0);
    tick();
    chk("lw_rd", {27'b0, MW_RD}, 32'd8);
    chk("lw_data", MW_ALUout, 32'hDEADBEEF);
    exec(3'd4, 32'h400, 32'd3, 32'hCAFEF00D, 5'd0);
    exec(3'd3, 32'd0, 32'd0, 32'd0, 5'd6);
    chk("wrap_lw", MW_ALUout, 32'hCAFEF00D);
    exec(3'd3, 32'h7FFFFFFC, 32'd4, 32'd0, 5'd6);
    chk("wrap_lw_hi_rd", {27'b0, MW_RD}, 32'd6);
    chk("wrap_lw_hi", MW_ALUout, 32'hCAFEF00D);
    // store caught in XM by reset must not reach memory
    exec(3'd4, 32'h80, 32'd0, 32'h11111111, 5'd0);
    drive(3'd4, 32'h80, 32'd0, 32'h22222222, 5'd0);
    tick();
    drive(3'd0, 32'd1, 32'd1, 32'd0, 5'd1);
    tick();
    drive(3'd7, 0, 0, 0, 0);
    tick();
    chk("pre_rst_rd", {27'b0, MW_RD}, 32'd1);
    drive(3'd4, 32'h80, 32'd0, 32'h33333333, 5'd0);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rd", {27'b0, MW_RD}, 32'd0);
    chk("async_rst_alu", MW_ALUout, 32'd0);
    chk("async_rst_ovf", {31'b0, ovf_flag}, 32'd0);
    drive(3'd7, 0, 0, 0, 0);
    tick();
    @(negedge clk);
    rst = 1'b0;
    exec(3'd3, 32'h80, 32'd0, 32'd0, 5'd10);
    chk("rst_drop_sw", MW_ALUout, 32'h22222222);
    exec(3'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 5'd5);
`ifdef OVERFLOW_TRAP_EN
    chk("ovf_add_rd", {27'b0, MW_RD}, 32'd0);
    chk("ovf_add_flag", {31'b0, ovf_flag}, 32'd1);
`else
    chk("ovf_add_rd", {27'b0, MW_RD}, 32'd5);
    chk("ovf_add_alu", MW_ALUout, 32'h80000000);
    chk("ovf_add_flag", {31'b0, ovf_flag}, 32'd0);
`endif
    exec(3'd1, 32'h80000000, 32'd1, 32'd0, 5'd11);
    chk("ovf_sub_alu", MW_ALUout, 32'h7FFFFFFF);
`ifdef OVERFLOW_TRAP_EN
    chk("ovf_sub_rd", {27'b0, MW_RD}, 32'd0);
`else
    chk("ovf_sub_rd", {27'b0, MW_RD}, 32'd11);
`endif
    exec(3'd0, 32'd2, 32'd3, 32'd0, 5'd12);
    chk("after_ovf_rd", {27'b0, MW_RD}, 32'd12);
    chk("after_ovf_alu", MW_ALUout, 32'd5);
`ifdef OVERFLOW_TRAP_EN
    chk("ovf_sticky", {31'b0, ovf_flag}, 32'd1);
`else
    chk("ovf_sticky", {31'b0, ovf_flag}, 32'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_memory_writeback.md
Name: execute_memory_writeback

Overview:
- Back end of the 5-stage MIPS pipeline.
- Consumes the decode-stage outputs (A, B, RD, ALUctr) plus store data.
- Performs the ALU operation, data-memory access for lw/sw, and drives the write-back pair MW_RD / MW_ALUout into the register file.
- Two registered stages: EX (X→M register) and MEM (M→W register).

Parameters:
- DM_DEPTH, 256, number of 32-bit words in data memory; power of two.
- DM_AW, 8, log2(DM_DEPTH); word-address width.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- A  input  32  operand A (rs value), registered by decode.
- B  input  32  operand B: rt value for R-type; sign-extended immediate for lw/sw.
- SD  input  32  store data (rt value) for sw; ignored otherwise.
- RD  input  5  destination register; 0 = no write-back.
- ALUctr  input  3  operation: 0 add, 1 sub, 2 slt, 3 lw, 4 sw, 5–7 nop.
- MW_RD  output  5  write-back register index to decode.
- MW_ALUout  output  32  write-back data to decode.
- ovf_flag  output  1  sticky overflow flag (meaningful only with the optional feature; 0 otherwise).

Behaviour:
- Reset (asynchronous, active-high):
  - XM_ALUout, XM_RD, XM_SD, XM_op, MW_RD, MW_ALUout and ovf_flag all go to 0.
  - Data memory is not reset.
  - Reset asserted mid-operation discards in-flight instructions; a pending sw that has not yet reached the MEM edge does not write.
- EX stage, every clock:
  - Add: XM_ALUout = A+B, 32-bit wrap.
  - Sub: XM_ALUout = A−B, 32-bit wrap.
  - slt: XM_ALUout = 1 if signed(A) < signed(B), else 0.
  - lw/sw: XM_ALUout = A+B (effective byte address).
  - XM_RD = RD for add/sub/slt/lw; XM_RD = 0 for sw and nop.
  - XM_SD = SD.
  - XM_op holds a 2-bit code: ALU, LOAD, STORE or NOP.
- MEM stage, every clock:
  - ALU: MW_ALUout = XM_ALUout; MW_RD = XM_RD.
  - LOAD: MW_ALUout = DM[XM_ALUout[DM_AW+1:2]]; MW_RD = XM_RD.
  - STORE: DM[XM_ALUout[DM_AW+1:2]] written with XM_SD; MW_RD = 0; MW_ALUout = XM_ALUout.
  - NOP: MW_RD = 0; MW_ALUout = 0.
- Latency: an instruction presented at edge n appears on MW_RD/MW_ALUout after edge n+2. Throughput is 1 per cycle; there is no stall or handshake.
- Address rules:
  - Byte address bits [1:0] are ignored (word aligned).
  - Bits above DM_AW+1 are ignored, so addresses wrap modulo DM_DEPTH words.
- Store followed immediately by a load to the same word: the load occupies MEM one cycle after the store, so it returns the new data.
- Store and load are never in MEM in the same cycle, so no simultaneous read/write occurs.
- MW_RD = 0 is a valid no-write; decode ignores it. The block never produces MW_RD ≠ 0 for sw or nop.
- ALUctr 5–7 are treated as nop.

Optional Feature:
- Macro: OVERFLOW_TRAP_EN.
- When defined:
  - Signed overflow on add (operand signs equal, result sign differs) or sub (operand signs differ, result sign differs from A) forces XM_RD = 0, so no write-back occurs.
  - The same condition sets ovf_flag on the MEM edge when the instruction reaches MEM.
  - ovf_flag is sticky until rst.
  - lw/sw address arithmetic never traps.
- When undefined: add/sub wrap silently, and ovf_flag is tied to 0.

Test Plan:
- Reset mid-stream: issue add, assert rst between edges → MW_RD = 0, MW_ALUout = 0, ovf_flag = 0 immediately (asynchronously).
- add A=5, B=7, RD=3 → after 2 edges MW_RD=3, MW_ALUout=12; sub A=5, B=7, RD=4 → MW_ALUout=0xFFFFFFFE.
- slt A=0xFFFFFFFF, B=1, RD=2 → MW_ALUout=1; slt A=1, B=0xFFFFFFFF → MW_ALUout=0.
- Back-to-back sw then lw: sw A=0x10, B=4, SD=0xDEADBEEF, then lw A=0x10, B=4, RD=8 → sw cycle gives MW_RD=0; next cycle MW_RD=8, MW_ALUout=0xDEADBEEF.
- Address wrap and alignment: sw at byte address 0x403 (DM_DEPTH=256), then lw at 0x000 → reads the stored word.
- With OVERFLOW_TRAP_EN: add A=0x7FFFFFFF, B=1, RD=5 → MW_RD=0, ovf_flag=1 and stays 1. Without the macro: MW_RD=5, MW_ALUout=0x80000000, ovf_flag=0.
